// File: rtl/kernel_kcore_fifo_param.sv
// kernel_kcore_fifo_param: show-ahead synchronous FIFO with occupancy count and almost-full/empty flags.
// Define KERNEL_KCORE_FIFO_ERR_EN to enable sticky overflow/underflow detection.
module kernel_kcore_fifo_param #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 128,
    parameter int ADDR_WIDTH = 7,
    parameter int AF_LEVEL   = 124,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    output logic                  if_full_n,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_empty_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic [ADDR_WIDTH:0]   if_count,
    output logic                  if_almost_full,
    output logic                  if_almost_empty,
    output logic                  err_overflow,
    output logic                  err_underflow
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AF   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr, rptr, wptr_n, rptr_n;
    logic [ADDR_WIDTH:0]   count_n;
    logic                  push, pop;

    always_comb begin
        push    = if_full_n & if_write_ce & if_write & ~flush;
        pop     = if_empty_n & if_read_ce & if_read & ~flush;
        wptr_n  = push ? (wptr == LAST ? '0 : wptr + 1'b1) : wptr;
        rptr_n  = pop ? (rptr == LAST ? '0 : rptr + 1'b1) : rptr;
        count_n = (push & ~pop) ? if_count + 1'b1 : (pop & ~push) ? if_count - 1'b1 : if_count;
    end

    // Flags are registered from next-cycle occupancy so they move with if_count.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr            <= '0;
            rptr            <= '0;
            if_count        <= '0;
            if_full_n       <= 1'b1;
            if_empty_n      <= 1'b0;
            if_almost_full  <= 1'b0;
            if_almost_empty <= 1'b1;
        end else begin
            wptr            <= wptr_n;
            rptr            <= rptr_n;
            if_count        <= count_n;
            if_full_n       <= count_n != FULL;
            if_empty_n      <= count_n != '0;
            if_almost_full  <= count_n >= AF;
            if_almost_empty <= count_n <= AE;
        end
    end

    // Storage is never cleared; the read pointer selects the head word combinationally.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= if_din;
    end

    assign if_dout = mem[rptr];

`ifdef KERNEL_KCORE_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            err_overflow  <= err_overflow | (if_write_ce & if_write & ~if_full_n & ~flush);
            err_underflow <= err_underflow | (if_read_ce & if_read & ~if_empty_n & ~flush);
        end
    end
`else
    assign err_overflow  = 1'b0;
    assign err_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_kernel_kcore_fifo_param.sv
// tb_kernel_kcore_fifo_param: directed plus random stimulus against a queue-based reference model.
module tb_kernel_kcore_fifo_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0, flush = 1'b0;
    logic       if_write_ce = 1'b0, if_write = 1'b0, if_read_ce = 1'b0, if_read = 1'b0;
    logic [7:0] if_din = '0;
    logic [7:0] if_dout;
    logic [3:0] if_count;
    logic       if_full_n, if_empty_n, if_almost_full, if_almost_empty, err_overflow, err_underflow;

    int         n_chk = 0, n_err = 0;
    logic [7:0] q[$];
    logic       m_ov = 1'b0, m_un = 1'b0;
    logic [7:0] nxt = 8'h00;

    kernel_kcore_fifo_param #(
        .DATA_WIDTH(8), .DEPTH(6), .ADDR_WIDTH(3), .AF_LEVEL(4), .AE_LEVEL(1)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .if_full_n(if_full_n), .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
        .if_empty_n(if_empty_n), .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout),
        .if_count(if_count), .if_almost_full(if_almost_full), .if_almost_empty(if_almost_empty),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic wr, input logic wce, input logic [7:0] d,
                         input logic rd, input logic rce, input logic fl, input logic rs);
        bit full, empty;
        reset = rs; flush = fl; if_write = wr; if_write_ce = wce; if_din = d;
        if_read = rd; if_read_ce = rce;
        full  = q.size() == 6;
        empty = q.size() == 0;
        @(posedge clk);
        if (rs) begin
            q.delete(); m_ov = 1'b0; m_un = 1'b0;
        end else if (fl) begin
            q.delete();
        end else begin
`ifdef KERNEL_KCORE_FIFO_ERR_EN
            m_ov = m_ov | (wr & wce & full);
            m_un = m_un | (rd & rce & empty);
`endif
            if (rd && rce && !empty) void'(q.pop_front());
            if (wr && wce && !full) q.push_back(d);
        end
        #1;
        chk("count", 32'(if_count), 32'(q.size()));
        chk("full_n", 32'(if_full_n), 32'(q.size() != 6));
        chk("empty_n", 32'(if_empty_n), 32'(q.size() != 0));
        chk("almost_full", 32'(if_almost_full), 32'(q.size() >= 4));
        chk("almost_empty", 32'(if_almost_empty), 32'(q.size() <= 1));
        chk("err_overflow", 32'(err_overflow), 32'(m_ov));
        chk("err_underflow", 32'(err_underflow), 32'(m_un));
        if (q.size() != 0) chk("dout", 32'(if_dout), 32'(q[0]));
    endtask

    initial begin
        cycle(0, 0, 8'h00, 0, 0, 0, 1);
        cycle(0, 0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) cycle(1, 1, 8'h11 + 8'(i), 0, 1, 0, 0);
        cycle(1, 1, 8'hEE, 0, 1, 0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 8'h00, 1, 1, 0, 0);
        cycle(1, 1, 8'hA5, 1, 1, 0, 0);
        cycle(1, 1, 8'h30, 0, 1, 0, 0);
        cycle(1, 1, 8'h31, 0, 1, 0, 0);
        for (int i = 0; i < 20; i++) cycle(1, 1, 8'h40 + 8'(i), 1, 1, 0, 0);
        cycle(1, 1, 8'h60, 0, 1, 0, 0);
        cycle(1, 1, 8'h61, 0, 1, 0, 0);
        cycle(1, 1, 8'h62, 1, 1, 1, 0);
        cycle(0, 0, 8'h00, 0, 0, 0, 1);
        for (int i = 0; i < 400; i++) begin
            nxt = 8'($urandom);
            cycle(1'($urandom), $urandom_range(0, 7) != 0, nxt,
                  1'($urandom), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 31) == 0, $urandom_range(0, 63) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
